// File: rtl/serial_parity_rx_if.sv
// Bundle between the serial line front end and the parallel consumer of serial_parity_rx.
// The slave modport is the receiver; the master modport is whoever drives the line and takes words.
interface serial_parity_rx_if #(
  parameter int DATA_W = 8
);
  logic              bit_en;
  logic              sdi;
  logic              dready;
  logic [DATA_W-1:0] dout;
  logic              dvalid;
  logic              perr;
  logic              ferr;
  logic              ovr;
  logic              busy;

  modport master (
    output bit_en, sdi, dready,
    input  dout, dvalid, perr, ferr, ovr, busy
  );

  modport slave (
    input  bit_en, sdi, dready,
    output dout, dvalid, perr, ferr, ovr, busy
  );
endinterface

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Checks XOR parity and framing; presents the word on a valid/ready output register.
//
// state  | meaning
// IDLE   | waiting for a start bit (SDI=0 on a strobe)
// DATA   | shifting in data bits, LSB first
// PARITY | folding the parity bit into the accumulator
// STOP   | sampling the stop bit and completing the frame
module serial_parity_rx #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  serial_parity_rx_if.slave bus
);
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              acc, acc_nx;
  logic [DATA_W-1:0] dout_q, dout_nx;
  logic              dvalid_q, dvalid_nx;
  logic              perr_q, perr_nx;
  logic              ferr_q, ferr_nx;
  logic              ovr_q, ovr_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      acc      <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      shreg    <= shreg_nx;
      cnt      <= cnt_nx;
      acc      <= acc_nx;
      dout_q   <= dout_nx;
      dvalid_q <= dvalid_nx;
      perr_q   <= perr_nx;
      ferr_q   <= ferr_nx;
      ovr_q    <= ovr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    cnt_nx    = cnt;
    acc_nx    = acc;
    dout_nx   = dout_q;
    dvalid_nx = dvalid_q;
    perr_nx   = perr_q;
    ferr_nx   = ferr_q;
    ovr_nx    = 1'b0;

    if (dvalid_q && bus.dready)
      dvalid_nx = 1'b0;

    if (bus.bit_en) begin
      unique case (state)
        IDLE: begin
          if (!bus.sdi) begin
            state_nx = DATA;
            cnt_nx   = '0;
            acc_nx   = PARITY_ODD;
          end
        end
        DATA: begin
          // right shift: first (LSB) bit ends up at bit 0 after DATA_W shifts
          for (int i = 0; i < DATA_W - 1; i++)
            shreg_nx[i] = shreg[i+1];
          shreg_nx[DATA_W-1] = bus.sdi;
          acc_nx = acc ^ bus.sdi;
          cnt_nx = cnt + CW'(1);
          if (cnt == CW'(DATA_W - 1))
            state_nx = PARITY;
        end
        PARITY: begin
          acc_nx   = acc ^ bus.sdi;
          state_nx = STOP;
        end
        STOP: begin
          state_nx = IDLE;
          // a simultaneous accept frees the register, so the new word loads instead of dropping
          if (dvalid_q && !bus.dready) begin
            ovr_nx = 1'b1;
          end else begin
            dout_nx   = shreg;
            perr_nx   = acc;
            ferr_nx   = ~bus.sdi;
            dvalid_nx = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign bus.dout   = dout_q;
  assign bus.dvalid = dvalid_q;
  assign bus.perr   = perr_q;
  assign bus.ferr   = ferr_q;
  assign bus.ovr    = ovr_q;
  assign bus.busy   = (state != IDLE);
endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx: table of single frames plus overrun, strobe-gap and reset sequences.
// An even-parity and an odd-parity instance share the same line stimulus.
module tb_serial_parity_rx;
  logic clk = 1'b0;
  logic rst_n;
  logic bit_en, sdi, dready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_parity_rx_if #(.DATA_W(8)) bus_e ();
  serial_parity_rx_if #(.DATA_W(8)) bus_o ();

  assign bus_e.bit_en = bit_en;
  assign bus_e.sdi    = sdi;
  assign bus_e.dready = dready;
  assign bus_o.bit_en = bit_en;
  assign bus_o.sdi    = sdi;
  assign bus_o.dready = dready;

  serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_e (
    .clk(clk), .rst_n(rst_n), .bus(bus_e.slave)
  );
  serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_o (
    .clk(clk), .rst_n(rst_n), .bus(bus_o.slave)
  );

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_perr_even;
    logic       exp_perr_odd;
    logic       exp_ferr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame, one bit per negedge; gap idle cycles with line noise precede each strobe.
  // Returns on the negedge right after the stop-bit strobe was sampled.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int gap, input bit rdy_at_stop, input bit expect_idle);
    logic [10:0] frame;
    frame = {s, p, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      for (int g = 0; g < gap; g++) begin
        bit_en = 1'b0;
        sdi    = 1'($urandom);
        @(negedge clk);
      end
      if (b == 10 && expect_idle) chk("dvalid_before_stop", bus_e.dvalid, 0);
      bit_en = 1'b1;
      sdi    = frame[b];
      dready = (b == 10) ? rdy_at_stop : 1'b0;
      @(negedge clk);
      if (b == 0) chk("busy_after_start", bus_e.busy, 1);
    end
    bit_en = 1'b0;
    sdi    = 1'b1;
    dready = 1'b0;
  endtask

  task automatic accept();
    dready = 1'b1;
    @(negedge clk);
    dready = 1'b0;
    chk("dvalid_cleared", bus_e.dvalid, 0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n  = 1'b0;
    bit_en = 1'b0;
    sdi    = 1'b1;
    dready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_dout", bus_e.dout, 0);
    chk("rst_dvalid", bus_e.dvalid, 0);
    chk("rst_busy", bus_e.busy, 0);
    chk("rst_ovr", bus_e.ovr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, 0, 1'b0, 1'b1);
      chk($sformatf("v%0d_dvalid", i), bus_e.dvalid, 1);
      chk($sformatf("v%0d_dout", i), bus_e.dout, vecs[i].data);
      chk($sformatf("v%0d_perr_even", i), bus_e.perr, vecs[i].exp_perr_even);
      chk($sformatf("v%0d_perr_odd", i), bus_o.perr, vecs[i].exp_perr_odd);
      chk($sformatf("v%0d_ferr", i), bus_e.ferr, vecs[i].exp_ferr);
      chk($sformatf("v%0d_ovr", i), bus_e.ovr, 0);
      chk($sformatf("v%0d_busy_done", i), bus_e.busy, 0);
      accept();
    end

    // overrun: second word dropped while the first is still held
    send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    chk("ovr1_dout", bus_e.dout, 8'h11);
    send_frame(8'h22, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    chk("ovr2_pulse", bus_e.ovr, 1);
    chk("ovr2_dout", bus_e.dout, 8'h11);
    chk("ovr2_dvalid", bus_e.dvalid, 1);
    @(negedge clk);
    chk("ovr2_pulse_end", bus_e.ovr, 0);
    accept();

    // accept in the completion cycle: new word loads, no overrun
    send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    chk("same_cyc_dout", bus_e.dout, 8'h22);
    chk("same_cyc_dvalid", bus_e.dvalid, 1);
    chk("same_cyc_ovr", bus_e.ovr, 0);
    accept();

    // strobe every 4th cycle with noise in between
    send_frame(8'hA5, 1'b0, 1'b1, 3, 1'b0, 1'b1);
    chk("gap_dvalid", bus_e.dvalid, 1);
    chk("gap_dout", bus_e.dout, 8'hA5);
    chk("gap_perr", bus_e.perr, 0);
    chk("gap_ferr", bus_e.ferr, 0);
    chk("gap_ovr", bus_e.ovr, 0);

    // reset mid-frame after 4 data bits; held word must be wiped too
    for (int b = 0; b < 5; b++) begin
      bit_en = 1'b1;
      sdi    = (b == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    bit_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_dout", bus_e.dout, 0);
    chk("mid_rst_dvalid", bus_e.dvalid, 0);
    chk("mid_rst_perr", bus_e.perr, 0);
    chk("mid_rst_ferr", bus_e.ferr, 0);
    chk("mid_rst_busy", bus_e.busy, 0);
    for (int c = 0; c < 12; c++) begin
      bit_en = 1'b1;
      sdi    = 1'b1;
      @(negedge clk);
      chk("post_rst_dvalid", bus_e.dvalid, 0);
      chk("post_rst_ovr", bus_e.ovr, 0);
    end
    bit_en = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    chk("post_rst_word_dvalid", bus_e.dvalid, 1);
    chk("post_rst_word_dout", bus_e.dout, 8'h5A);
    chk("post_rst_word_perr", bus_e.perr, 0);
    chk("post_rst_word_ferr", bus_e.ferr, 0);
    accept();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_parity_rx.md
# serial_parity_rx

Serial frame receiver that checks the XOR parity and framing of an incoming bit stream. It is the receiving end of the team's XOR parity generator and serial transmitter path. Each frame is deserialized into a parallel word, checked against the configured parity sense, and presented on a valid/ready output register. The block sits between the serial line (already synchronized, with an external bit-rate strobe) and the parallel consumer logic.

## Interface
- DATA_W, default 8: data bits per frame; legal range 1-16.
- PARITY_ODD, default 0: 0 = even parity (XOR of data and parity bit is 0); 1 = odd parity (XOR is 1).
- CLK  in  1  single clock; all logic is rising-edge.
- RST_N  in  1  synchronous, active-low reset.
- BIT_EN  in  1  bit strobe; SDI is sampled only in cycles where BIT_EN=1.
- SDI  in  1  serial data, already synchronized to CLK.
- DREADY  in  1  consumer accepts the held word when DVALID=1 and DREADY=1.
- DOUT  out  DATA_W  received data word, registered.
- DVALID  out  1  DOUT, PERR and FERR are valid; held until accepted.
- PERR  out  1  parity error for the word on DOUT.
- FERR  out  1  framing error (stop bit sampled as 0) for the word on DOUT.
- OVR  out  1  one-cycle pulse: a completed frame was dropped because the output was still occupied.
- BUSY  out  1  high whenever the FSM is not in IDLE.

## Operation
- Frame format on SDI, one bit per BIT_EN: start (0), DATA_W data bits sent LSB first, one parity bit, stop (1).
- FSM states:
  - IDLE: on BIT_EN with SDI=0, go to DATA, clear the bit counter, and set the parity accumulator to PARITY_ODD. BIT_EN with SDI=1 leaves the FSM in IDLE.
  - DATA: on each BIT_EN, shift SDI into the MSB of the shift register (right shift) and XOR SDI into the accumulator. After the DATA_W-th bit, go to PARITY.
  - PARITY: on BIT_EN, XOR SDI into the accumulator and go to STOP.
  - STOP: on BIT_EN, complete the frame and go to IDLE.
- Frame completion:
  - If DVALID=1 and DREADY=0: drop the frame, pulse OVR, and leave DOUT, PERR and FERR unchanged.
  - Otherwise: DOUT = shift register, PERR = accumulator (nonzero means error), FERR = ~SDI, DVALID = 1.
- A word is delivered even when PERR or FERR is set; the consumer decides what to do with it.
- Output handshake: DVALID clears in the cycle after DVALID=1 and DREADY=1, unless a new frame completes in that same cycle. In that case the new word loads, DVALID stays 1, and OVR is not pulsed.
- Cycles with BIT_EN=0 hold all FSM state. Gaps of any length between strobes are legal.
- The bit counter is $clog2(DATA_W+1) bits wide and never wraps within a frame.

## Timing
- Reset (RST_N=0 at a rising edge): FSM to IDLE; DOUT=0, DVALID=0, PERR=0, FERR=0, OVR=0, BUSY=0. The shift register, counter and accumulator are cleared.
- Reset mid-frame aborts the frame. No output and no OVR are produced, and reception restarts at the next start bit.
- BUSY rises in the cycle after the start-bit strobe and falls in the cycle after the stop-bit strobe.
- Latency: DVALID, DOUT, PERR and FERR update in the cycle after the BIT_EN cycle that samples the stop bit.
- OVR is high for exactly one cycle, aligned with the cycle the word would have loaded.
- DREADY is ignored while DVALID=0.
- Minimum frame length is DATA_W+3 BIT_EN strobes. BIT_EN may be held high every cycle.

## Test plan
- Even parity, DATA_W=8, BIT_EN every cycle. Send 0xA5: SDI sequence 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. Required: DOUT=0xA5, PERR=0, FERR=0, DVALID=1 one cycle after the stop strobe; DVALID clears after DREADY=1.
- Same frame with parity bit 1. Required: DOUT=0xA5, PERR=1. With PARITY_ODD=1 and parity bit 1: PERR=0.
- Send 0x3C with stop bit 0. Required: DOUT=0x3C, FERR=1, PERR=0; the FSM returns to IDLE and accepts the next frame normally.
- DREADY held 0. Send 0x11 then 0x22. Required: DOUT stays 0x11, OVR pulses one cycle at the second completion. Repeat with DREADY=1 only in the second frame's completion cycle. Required: DOUT=0x22, DVALID=1, no OVR.
- BIT_EN asserted every 4th cycle with random SDI noise between strobes. Required: same result as the first scenario (0xA5, no errors).
- Assert RST_N=0 for one cycle after 4 data bits, then send 0x5A. Required: all outputs 0 after reset, no spurious word or OVR, then DOUT=0x5A with no errors.
